// File: rtl/mod_inv_bin_hs.sv
// Binary extended-Euclid modular inverter, one reduction step per clock, valid/ready on both sides.
// Optional MODINV_MONT_EN: adds i_init so x1 starts at i_init, giving o_inv = i_init * a^-1 mod p.
module mod_inv_bin_hs #(
  parameter int W        = 256,
  parameter int MAX_ITER = 2*W,
  parameter int CNT_W    = $clog2(2*W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_p,
`ifdef MODINV_MONT_EN
  input  logic [W-1:0]     i_init,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     o_inv,
  output logic             o_err,
  output logic [CNT_W-1:0] o_iter
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);
  localparam logic [W-1:0]     ONE     = W'(1);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     u_q, u_d, v_q, v_d;
  logic [W-1:0]     x1_q, x1_d, x2_q, x2_d;
  logic [W-1:0]     p_q, p_d;
  logic [CNT_W-1:0] it_q, it_d;
  logic [W-1:0]     inv_q, inv_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [W-1:0]     x1_start;
  logic             bad_operand;

  // x/2 mod p for x in [0,p): odd x is made even by adding p, using a carry bit.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x, input logic [W-1:0] p);
    logic [W:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, p} : {(W+1){1'b0}});
    return s[W:1];
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] p);
    return (x >= y) ? (x - y) : (x - y + p);
  endfunction

`ifdef MODINV_MONT_EN
  assign x1_start    = i_init;
  assign bad_operand = (i_a == '0) || (i_a >= i_p) || !i_p[0] || (i_init >= i_p);
`else
  assign x1_start    = ONE;
  assign bad_operand = (i_a == '0) || (i_a >= i_p) || !i_p[0];
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign o_inv     = inv_q;
  assign o_err     = err_q;
  assign o_iter    = iter_q;

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    p_d     = p_q;
    it_d    = it_q;
    inv_d   = inv_q;
    err_d   = err_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          u_d  = i_a;
          v_d  = i_p;
          x1_d = x1_start;
          x2_d = '0;
          p_d  = i_p;
          it_d = '0;
          if (bad_operand) begin
            state_d = DONE;
            inv_d   = '0;
            err_d   = 1'b1;
            iter_d  = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Termination looks at the registered u/v before this cycle's step.
        if (u_q == ONE) begin
          state_d = DONE;
          inv_d   = x1_q;
          err_d   = 1'b0;
          iter_d  = it_q;
        end else if (v_q == ONE) begin
          state_d = DONE;
          inv_d   = x2_q;
          err_d   = 1'b0;
          iter_d  = it_q;
        end else if ((u_q == '0) || (it_q == MAX_CNT)) begin
          state_d = DONE;
          inv_d   = '0;
          err_d   = 1'b1;
          iter_d  = it_q;
        end else begin
          it_d = it_q + CNT_W'(1);
          if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = half_mod(x1_q, p_q);
          end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = half_mod(x2_q, p_q);
          end else if (u_q >= v_q) begin
            u_d  = u_q - v_q;
            x1_d = sub_mod(x1_q, x2_q, p_q);
          end else begin
            v_d  = v_q - u_q;
            x2_d = sub_mod(x2_q, x1_q, p_q);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      p_q     <= '0;
      it_q    <= '0;
      inv_q   <= '0;
      err_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      p_q     <= p_d;
      it_q    <= it_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: tb/tb_mod_inv_bin_hs.sv
// Scoreboard bench for mod_inv_bin_hs at W=8: directed spec cases, random operands, backpressure, reset abort.
module tb_mod_inv_bin_hs;
  localparam int W        = 8;
  localparam int MAX_ITER = 2*W;
  localparam int CNT_W    = $clog2(2*W+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     i_a = '0;
  logic [W-1:0]     i_p = '0;
`ifdef MODINV_MONT_EN
  logic [W-1:0]     i_init = '0;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     o_inv;
  logic             o_err;
  logic [CNT_W-1:0] o_iter;

  mod_inv_bin_hs #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i_a(i_a), .i_p(i_p),
`ifdef MODINV_MONT_EN
    .i_init(i_init),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .o_inv(o_inv), .o_err(o_err), .o_iter(o_iter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a, p, init, inv, err, iter, lat, xfer;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int rdy_mode = 0;   // 0 random, 1 held low, 2 held high
  bit vseen = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour of the inverter written over plain integers.
  function automatic void model(input int a, input int p, input int init,
                                output int inv, output int err, output int iter, output int lat);
    int u, v, x1, x2, t;
    inv = 0; err = 1; iter = 0; lat = 0;
    if (a == 0 || a >= p || p % 2 == 0 || init >= p) return;
    u = a; v = p; x1 = init; x2 = 0; t = 0;
    while (1) begin
      if (u == 1 || v == 1) begin
        inv = (u == 1) ? x1 : x2; err = 0; iter = t; lat = t + 1; return;
      end
      if (u == 0 || t == MAX_ITER) begin
        inv = 0; err = 1; iter = t; lat = t + 1; return;
      end
      if (u % 2 == 0) begin
        u = u / 2; x1 = (x1 % 2 == 0) ? x1 / 2 : (x1 + p) / 2;
      end else if (v % 2 == 0) begin
        v = v / 2; x2 = (x2 % 2 == 0) ? x2 / 2 : (x2 + p) / 2;
      end else if (u >= v) begin
        u = u - v; x1 = (x1 >= x2) ? x1 - x2 : x1 - x2 + p;
      end else begin
        v = v - u; x2 = (x2 >= x1) ? x2 - x1 : x2 - x1 + p;
      end
      t++;
    end
  endfunction

  task automatic send(input int a, input int p, input int init);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    i_a = a[W-1:0];
    i_p = p[W-1:0];
`ifdef MODINV_MONT_EN
    i_init = init[W-1:0];
`endif
    in_valid = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("xfer_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    e.a = a; e.p = p; e.init = init; e.xfer = cyc + 1;
    model(a, p, init, e.inv, e.err, e.iter, e.lat);
    sb.push_back(e);
    $display("send a=%0d p=%0d init=%0d -> exp inv=%0d err=%0d iter=%0d", a, p, init, e.inv, e.err, e.iter);
    @(negedge clk);
    in_valid = 1'b0;
    i_a = $urandom_range(0, 255);
    i_p = $urandom_range(0, 255);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("drain_timeout", sb.size(), 0);
        sb.delete();
      end
    end
  endtask

  // Output side: drives out_ready and checks every cycle out_valid is high.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1: out_ready = 1'b0;
        2: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = sb[0];
          if (!vseen) begin
            vseen = 1;
            check("latency", cyc - e.xfer, e.lat);
          end
          check("o_inv", o_inv, e.inv);
          check("o_err", o_err, e.err);
          check("o_iter", o_iter, e.iter);
          check("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            if (e.err == 0) check("a_times_inv", (e.a * int'(o_inv)) % e.p, e.init % e.p);
            $display("result a=%0d p=%0d inv=%0d err=%0d iter=%0d", e.a, e.p, o_inv, o_err, o_iter);
            void'(sb.pop_front());
            vseen = 0;
          end
        end
      end
    end
  end

  initial begin
    int p, a, n;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_o_inv", o_inv, 0);
    check("rst_o_err", o_err, 0);
    check("rst_o_iter", o_iter, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    rdy_mode = 2;
    send(3, 11, 1);
    send(1, 11, 1);
    send(0, 11, 1);
    send(4, 12, 1);
    send(12, 11, 1);
    send(3, 9, 1);
    drain();

    // backpressure: hold out_ready low for five cycles of out_valid
    @(posedge clk);
    rdy_mode = 1;
    send(10, 11, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_o_inv", o_inv, 10);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_dropped", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);
    drain();

`ifdef MODINV_MONT_EN
    send(9, 11, 9);
    send(3, 11, 11);
    drain();
`endif

    // random operands, some illegal
    rdy_mode = 0;
    for (int k = 0; k < 60; k++) begin
      p = $urandom_range(3, 255);
      if (k % 7 != 0) p = p | 1;
      a = $urandom_range(0, p + 2);
      if (a > 255) a = 255;
      send(a, p, 1);
    end
    drain();

    // reset while RUN aborts and drops the pending result
    rdy_mode = 2;
    send(200, 251, 1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    vseen = 0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_in_ready", in_ready, 1);
    check("abort_idle_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    check("abort_no_result", out_valid, 0);

    send(7, 13, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
